stage_id_pipe: RTL and testbench
================================

STAGE_ID_PIPE -- requirements
Module: stage_id_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/register width.
REQ-002 SHALL have parameter NUM_REG, default 32, register count; REG_ADDR_WIDTH = clog2(NUM_REG).
REQ-003 SHALL have parameter PC_WIDTH, default 32; INST_WIDTH fixed 32.
REQ-004 SHALL have ports, one clock, reset synchronous active-high:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- if_id_valid  in  1  IF/ID holds a live instruction
- if_id_pc  in  PC_WIDTH  IF/ID PC
- if_id_inst  in  32  IF/ID instruction
- ex_rd, mem_rd, wb_rd  in  REG_ADDR_WIDTH  destination of EX/MEM/WB instruction
- ex_reg_wr_en, mem_reg_wr_en, wb_reg_wr_en  in  1  stage writes its rd
- mem_data  in  XLEN  final MEM-stage result (ALU or load data)
- wb_data  in  XLEN  write-back data
- stall_if  out  1  hold PC and IF/ID this cycle
- flush_if  out  1  squash IF/ID next edge
- pc_sel  out  1  redirect fetch to pc_target
- pc_target  out  PC_WIDTH  branch/jump target
- id_ex_valid  out  1  ID/EX holds a live instruction
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  PC_WIDTH/XLEN/XLEN/XLEN  ID/EX payload
- id_ex_rd  out  REG_ADDR_WIDTH; id_ex_opcode  out  7; id_ex_funct3  out  3; id_ex_funct7b5  out  1
- stall_cnt, flush_cnt  out  32  saturating performance counters

Function
REQ-005 SHALL hold register file: NUM_REG x XLEN, x0 reads 0 and ignores writes, written at clk edge when wb_reg_wr_en; same-cycle read of wb_rd returns wb_data (write-first).
REQ-006 SHALL decode immediate by opcode: I (0010011,0000011,1100111), S (0100011), B (1100011), U (0110111,0010111), J (1101111), sign-extended to XLEN; others 0.
REQ-007 SHALL mark rs1 used for opcodes I/S/B/JALR, rs2 used for R (0110011)/S/B; unused operands never cause stalls.
REQ-008 SHALL forward operands with priority MEM (mem_reg_wr_en, mem_rd==rs, rs!=0) > WB > register file.
REQ-009 SHALL assert stall_if combinationally when if_id_valid, ex_reg_wr_en, ex_rd!=0 and ex_rd equals a used rs; one-cycle stall per EX dependency.
REQ-010 SHALL, while stalled, load ID/EX with bubble (id_ex_valid=0, payload 0) and suppress pc_sel/flush_if.
REQ-011 SHALL resolve control flow in ID when if_id_valid and not stalled: BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned on forwarded operands; JAL always taken; JALR always taken.
REQ-012 SHALL compute pc_target = if_id_pc + imm (B, J), (rs1 + imm) & ~1 (JALR), truncated to PC_WIDTH.
REQ-013 SHALL assert pc_sel and flush_if same cycle when taken; instruction itself still enters ID/EX valid.
REQ-014 SHALL, with if_id_valid=0, load a bubble and assert no stall, redirect or counter increment.
REQ-015 SHALL increment stall_cnt each stalled cycle and flush_cnt each taken cycle, saturating at 2^32-1.
REQ-016 SHALL register ID/EX payload with latency 1 cycle from IF/ID; unknown opcodes pass with valid=1, imm=0.

Reset
REQ-017 SHALL on reset clear id_ex_valid and all id_ex_* to 0, stall_cnt/flush_cnt to 0, register file to 0.
REQ-018 SHALL, with reset asserted, drive stall_if, flush_if, pc_sel to 0; reset mid-stall discards the stall.

Structure
REQ-019 SHALL place opcode constants, funct3 branch codes and immediate-type enum in shared package risc_v_pkg.
REQ-020 SHALL instantiate one sub-module reg_file (parametrised NUM_REG, XLEN, synchronous active-high reset); immediate, forwarding, hazard logic inline.

Verification
REQ-021 SHALL cover: ADD x3 after x3 write in EX -> stall_if=1 one cycle, id_ex_valid=0, then rs data = mem_data.
REQ-022 SHALL cover: BEQ x1,x2 with x1=x2=5 via WB forward, pc=0x100, imm=0x20 -> pc_sel=1, flush_if=1, pc_target=0x120.
REQ-023 SHALL cover: BLTU 0xFFFFFFFF vs 1 -> not taken; BLT same operands -> taken.
REQ-024 SHALL cover: JALR rs1=0x203, imm=4 -> pc_target=0x206; write to x0 -> reads remain 0.
REQ-025 SHALL cover: MEM and WB both writing x5 (0xA, 0xB) -> rs1 data=0xA; reset during stall -> next cycle outputs all 0.
REQ-026 SHALL cover: force stall_cnt to 0xFFFFFFFF, further stall -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Shared RISC-V decode constants: opcodes, branch funct3 codes and the
// immediate-format enum used by the ID stage.
package risc_v_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: x0 hardwired to zero, write-first read bypass so a
// same-cycle write of the read address is visible immediately.
module reg_file #(
    parameter  int NUM_REG = 32,
    parameter  int XLEN    = 32,
    localparam int ADDR_W  = $clog2(NUM_REG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
);

    logic [XLEN-1:0] regs_q [NUM_REG];
    logic [XLEN-1:0] regs_d [NUM_REG];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
        if (wr_en && wr_addr == rs1_addr) rs1_data = wr_data;
        if (wr_en && wr_addr == rs2_addr) rs2_data = wr_data;
        if (rs1_addr == '0) rs1_data = '0;
        if (rs2_addr == '0) rs2_data = '0;
    end

endmodule

// File: rtl/stage_id_pipe.sv
// Instruction-decode stage: register read with MEM/WB forwarding, load-use
// style stall against EX, branch/jump resolution and the ID/EX register.
module stage_id_pipe
    import risc_v_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int NUM_REG        = 32,
    parameter  int PC_WIDTH       = 32,
    localparam int REG_ADDR_WIDTH = $clog2(NUM_REG),
    localparam int INST_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_id_valid,
    input  logic [PC_WIDTH-1:0]       if_id_pc,
    input  logic [INST_WIDTH-1:0]     if_id_inst,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      ex_reg_wr_en,
    input  logic                      mem_reg_wr_en,
    input  logic                      wb_reg_wr_en,
    input  logic [XLEN-1:0]           mem_data,
    input  logic [XLEN-1:0]           wb_data,
    output logic                      stall_if,
    output logic                      flush_if,
    output logic                      pc_sel,
    output logic [PC_WIDTH-1:0]       pc_target,
    output logic                      id_ex_valid,
    output logic [PC_WIDTH-1:0]       id_ex_pc,
    output logic [XLEN-1:0]           id_ex_rs1_data,
    output logic [XLEN-1:0]           id_ex_rs2_data,
    output logic [XLEN-1:0]           id_ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
    output logic [6:0]                id_ex_opcode,
    output logic [2:0]                id_ex_funct3,
    output logic                      id_ex_funct7b5,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rd_addr, rs1_addr, rs2_addr;
    imm_type_e                 imm_type;
    logic [31:0]               imm32;
    logic signed [XLEN-1:0]    imm;

    assign opcode   = if_id_inst[6:0];
    assign funct3   = if_id_inst[14:12];
    assign rd_addr  = REG_ADDR_WIDTH'(if_id_inst[11:7]);
    assign rs1_addr = REG_ADDR_WIDTH'(if_id_inst[19:15]);
    assign rs2_addr = REG_ADDR_WIDTH'(if_id_inst[24:20]);
    assign imm_type = imm_type_of(opcode);

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{if_id_inst[31]}}, if_id_inst[31:20]};
            IMM_S: imm32 = {{20{if_id_inst[31]}}, if_id_inst[31:25], if_id_inst[11:7]};
            IMM_B: imm32 = {{19{if_id_inst[31]}}, if_id_inst[31], if_id_inst[7],
                            if_id_inst[30:25], if_id_inst[11:8], 1'b0};
            IMM_U: imm32 = {if_id_inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{if_id_inst[31]}}, if_id_inst[31], if_id_inst[19:12],
                            if_id_inst[20], if_id_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;

    reg_file #(
        .NUM_REG (NUM_REG),
        .XLEN    (XLEN)
    ) u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_reg_wr_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data)
    );

    // MEM holds the younger result, so it wins over WB for the same register.
    logic [XLEN-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = rf_rs1_data;
        if (mem_reg_wr_en && mem_rd == rs1_addr && rs1_addr != '0) begin
            rs1_val = mem_data;
        end else if (wb_reg_wr_en && wb_rd == rs1_addr && rs1_addr != '0) begin
            rs1_val = wb_data;
        end
        rs2_val = rf_rs2_data;
        if (mem_reg_wr_en && mem_rd == rs2_addr && rs2_addr != '0) begin
            rs2_val = mem_data;
        end else if (wb_reg_wr_en && wb_rd == rs2_addr && rs2_addr != '0) begin
            rs2_val = wb_data;
        end
    end

    logic rs1_used, rs2_used, stall, take_raw, taken;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: rs1_used = 1'b1;
            OPC_STORE, OPC_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP:  rs2_used = 1'b1;
            default: ;
        endcase
    end

    // The EX result is not yet available to forward, so a dependent
    // instruction waits one cycle and picks it up from MEM.
    assign stall = !reset && if_id_valid && ex_reg_wr_en && ex_rd != '0 &&
                   ((rs1_used && ex_rd == rs1_addr) || (rs2_used && ex_rd == rs2_addr));

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    assign rs1_s = rs1_val;
    assign rs2_s = rs2_val;

    always_comb begin
        take_raw = 1'b0;
        case (opcode)
            OPC_JAL, OPC_JALR: take_raw = 1'b1;
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ:  take_raw = (rs1_val == rs2_val);
                    F3_BNE:  take_raw = (rs1_val != rs2_val);
                    F3_BLT:  take_raw = (rs1_s < rs2_s);
                    F3_BGE:  take_raw = (rs1_s >= rs2_s);
                    F3_BLTU: take_raw = (rs1_val < rs2_val);
                    F3_BGEU: take_raw = (rs1_val >= rs2_val);
                    default: take_raw = 1'b0;
                endcase
            end
            default: take_raw = 1'b0;
        endcase
    end

    assign taken = !reset && if_id_valid && !stall && take_raw;

    logic [XLEN-1:0] jalr_sum;
    assign jalr_sum = rs1_val + imm;

    always_comb begin
        pc_target = if_id_pc + PC_WIDTH'(imm);
        if (opcode == OPC_JALR) begin
            pc_target = PC_WIDTH'(jalr_sum) & ~PC_WIDTH'(1);
        end
    end

    assign stall_if = stall;
    assign flush_if = taken;
    assign pc_sel   = taken;

    logic                      valid_d, valid_q;
    logic [PC_WIDTH-1:0]       pc_d, pc_q;
    logic [XLEN-1:0]           rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q;
    logic [REG_ADDR_WIDTH-1:0] rd_d, rd_q;
    logic [6:0]                opcode_d, opcode_q;
    logic [2:0]                funct3_d, funct3_q;
    logic                      funct7b5_d, funct7b5_q;
    logic [31:0]               stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        imm_d      = '0;
        rd_d       = '0;
        opcode_d   = '0;
        funct3_d   = '0;
        funct7b5_d = 1'b0;
        if (if_id_valid && !stall) begin
            valid_d    = 1'b1;
            pc_d       = if_id_pc;
            rs1_d      = rs1_val;
            rs2_d      = rs2_val;
            imm_d      = imm;
            rd_d       = rd_addr;
            opcode_d   = opcode;
            funct3_d   = funct3;
            funct7b5_d = if_id_inst[30];
        end
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = taken ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_ex_valid    = valid_q;
    assign id_ex_pc       = pc_q;
    assign id_ex_rs1_data = rs1_q;
    assign id_ex_rs2_data = rs2_q;
    assign id_ex_imm      = imm_q;
    assign id_ex_rd       = rd_q;
    assign id_ex_opcode   = opcode_q;
    assign id_ex_funct3   = funct3_q;
    assign id_ex_funct7b5 = funct7b5_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Scoreboard bench for stage_id_pipe: hand-built instruction stream with
// expected ID/EX contents queued at drive time and checked one edge later.
module tb_stage_id_pipe;

    localparam int XLEN     = 32;
    localparam int NUM_REG  = 32;
    localparam int PC_WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_inst;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_reg_wr_en, mem_reg_wr_en, wb_reg_wr_en;
    logic [31:0] mem_data, wb_data;
    logic        stall_if, flush_if, pc_sel;
    logic [31:0] pc_target;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic [6:0]  id_ex_opcode;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    stage_id_pipe #(
        .XLEN     (XLEN),
        .NUM_REG  (NUM_REG),
        .PC_WIDTH (PC_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
        .ex_rd          (ex_rd),
        .mem_rd         (mem_rd),
        .wb_rd          (wb_rd),
        .ex_reg_wr_en   (ex_reg_wr_en),
        .mem_reg_wr_en  (mem_reg_wr_en),
        .wb_reg_wr_en   (wb_reg_wr_en),
        .mem_data       (mem_data),
        .wb_data        (wb_data),
        .stall_if       (stall_if),
        .flush_if       (flush_if),
        .pc_sel         (pc_sel),
        .pc_target      (pc_target),
        .id_ex_valid    (id_ex_valid),
        .id_ex_pc       (id_ex_pc),
        .id_ex_rs1_data (id_ex_rs1_data),
        .id_ex_rs2_data (id_ex_rs2_data),
        .id_ex_imm      (id_ex_imm),
        .id_ex_rd       (id_ex_rd),
        .id_ex_opcode   (id_ex_opcode),
        .id_ex_funct3   (id_ex_funct3),
        .id_ex_funct7b5 (id_ex_funct7b5),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    typedef struct {
        logic        rst, v;
        logic [31:0] pc, inst;
        logic        ex_we, mem_we, wb_we;
        logic [4:0]  ex_rd, mem_rd, wb_rd;
        logic [31:0] mem_data, wb_data;
    } stim_t;

    typedef struct {
        logic        stall, taken;
        logic [31:0] target;
        logic        vld;
        logic [31:0] pc, rs1, rs2, imm;
        logic [15:0] ctl;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_scnt = '0;
    logic [31:0] exp_fcnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.v = 1'b0; s.pc = '0; s.inst = '0;
        s.ex_we = 1'b0; s.mem_we = 1'b0; s.wb_we = 1'b0;
        s.ex_rd = '0; s.mem_rd = '0; s.wb_rd = '0;
        s.mem_data = '0; s.wb_data = '0;
        return s;
    endfunction

    function automatic stim_t st(input logic [31:0] pc, input logic [31:0] inst);
        stim_t s = idle();
        s.v = 1'b1; s.pc = pc; s.inst = inst;
        return s;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.stall = 1'b0; e.taken = 1'b0; e.target = '0; e.vld = 1'b0;
        e.pc = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0; e.ctl = '0;
        return e;
    endfunction

    function automatic exp_t stalled();
        exp_t e = bubble();
        e.stall = 1'b1;
        return e;
    endfunction

    function automatic exp_t live(input logic [31:0] pc, input logic [31:0] inst,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm);
        exp_t e = bubble();
        e.vld = 1'b1; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        e.ctl = {inst[11:7], inst[6:0], inst[14:12], inst[30]};
        return e;
    endfunction

    function automatic exp_t jump(input exp_t base, input logic [31:0] target);
        exp_t e = base;
        e.taken = 1'b1; e.target = target;
        return e;
    endfunction

    task automatic cycle(input stim_t s, input exp_t e);
        exp_t g;
        reset         = s.rst;
        if_id_valid   = s.v;
        if_id_pc      = s.pc;
        if_id_inst    = s.inst;
        ex_reg_wr_en  = s.ex_we;
        ex_rd         = s.ex_rd;
        mem_reg_wr_en = s.mem_we;
        mem_rd        = s.mem_rd;
        mem_data      = s.mem_data;
        wb_reg_wr_en  = s.wb_we;
        wb_rd         = s.wb_rd;
        wb_data       = s.wb_data;
        sb.push_back(e);
        @(negedge clk);
        check_eq("stall_if", 32'(stall_if), 32'(e.stall));
        check_eq("flush_if", 32'(flush_if), 32'(e.taken));
        check_eq("pc_sel", 32'(pc_sel), 32'(e.taken));
        if (e.taken) check_eq("pc_target", pc_target, e.target);
        if (s.rst) begin
            exp_scnt = '0;
            exp_fcnt = '0;
        end else begin
            if (e.stall && exp_scnt != '1) exp_scnt = exp_scnt + 32'd1;
            if (e.taken && exp_fcnt != '1) exp_fcnt = exp_fcnt + 32'd1;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            check_eq("id_ex_valid", 32'(id_ex_valid), 32'(g.vld));
            check_eq("id_ex_pc", id_ex_pc, g.pc);
            check_eq("id_ex_rs1", id_ex_rs1_data, g.rs1);
            check_eq("id_ex_rs2", id_ex_rs2_data, g.rs2);
            check_eq("id_ex_imm", id_ex_imm, g.imm);
            check_eq("id_ex_ctl", 32'({id_ex_rd, id_ex_opcode, id_ex_funct3, id_ex_funct7b5}),
                     32'(g.ctl));
        end
        check_eq("stall_cnt", stall_cnt, exp_scnt);
        check_eq("flush_cnt", flush_cnt, exp_fcnt);
    endtask

    initial begin
        stim_t       s;
        logic [31:0] add_x3, beq, bltu, blt, bne, jalr, jal, addi_x0, addi_x5, sw, unk, lui, addi_x1;

        add_x3  = enc_r(7'b0, 5'd3, 5'd3, 3'b000, 5'd4);
        beq     = enc_b(13'h0020, 5'd2, 5'd1, 3'b000);
        bltu    = enc_b(13'h0010, 5'd7, 5'd6, 3'b110);
        blt     = enc_b(13'h1FF8, 5'd7, 5'd6, 3'b100);
        bne     = enc_b(13'h0010, 5'd2, 5'd1, 3'b001);
        jalr    = enc_i(12'h004, 5'd8, 3'b000, 5'd1, 7'b1100111);
        jal     = enc_j(21'h000040, 5'd1);
        addi_x0 = enc_i(12'h000, 5'd0, 3'b000, 5'd9, 7'b0010011);
        addi_x5 = enc_i(12'h001, 5'd5, 3'b000, 5'd10, 7'b0010011);
        sw      = enc_s(12'hFFC, 5'd5, 5'd6, 3'b010);
        unk     = 32'h4010_80FF;
        lui     = {20'hABCDE, 5'd11, 7'b0110111};
        addi_x1 = enc_i(12'h000, 5'd1, 3'b000, 5'd12, 7'b0010011);

        // Reset with a would-be stall and a jump in ID: no control outputs.
        s = st(32'h40, add_x3); s.rst = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd3;
        cycle(s, bubble());
        s = st(32'h400, jal); s.rst = 1'b1;
        cycle(s, bubble());

        // Bubbles that load the register file; first one carries a dependency.
        s = idle(); s.inst = add_x3; s.ex_we = 1'b1; s.ex_rd = 5'd3;
        s.wb_we = 1'b1; s.wb_rd = 5'd1; s.wb_data = 32'd5;
        cycle(s, bubble());
        s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd6; s.wb_data = 32'hFFFF_FFFF;
        cycle(s, bubble());
        s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd8; s.wb_data = 32'h203;
        cycle(s, bubble());
        s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'hDEAD;
        cycle(s, bubble());

        // EX dependency stalls once, then the value arrives through MEM.
        s = st(32'h40, add_x3); s.ex_we = 1'b1; s.ex_rd = 5'd3;
        cycle(s, stalled());
        s = st(32'h40, add_x3); s.mem_we = 1'b1; s.mem_rd = 5'd3; s.mem_data = 32'h1234;
        cycle(s, live(32'h40, add_x3, 32'h1234, 32'h1234, 32'h0));

        // Stalled branch must not redirect; then BEQ taken via WB forward.
        s = st(32'h100, beq); s.ex_we = 1'b1; s.ex_rd = 5'd2;
        cycle(s, stalled());
        s = st(32'h100, beq); s.wb_we = 1'b1; s.wb_rd = 5'd2; s.wb_data = 32'd5;
        cycle(s, jump(live(32'h100, beq, 32'd5, 32'd5, 32'h20), 32'h120));

        // Unsigned vs signed compare of 0xFFFFFFFF against 1.
        s = st(32'h200, bltu); s.mem_we = 1'b1; s.mem_rd = 5'd7; s.mem_data = 32'd1;
        cycle(s, live(32'h200, bltu, 32'hFFFF_FFFF, 32'd1, 32'h10));
        s = st(32'h204, blt); s.mem_we = 1'b1; s.mem_rd = 5'd7; s.mem_data = 32'd1;
        cycle(s, jump(live(32'h204, blt, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8), 32'h1FC));
        s = st(32'h208, bne);
        cycle(s, live(32'h208, bne, 32'd5, 32'd5, 32'h10));

        // Jumps.
        s = st(32'h300, jalr);
        cycle(s, jump(live(32'h300, jalr, 32'h203, 32'h0, 32'h4), 32'h206));
        s = st(32'h400, jal);
        cycle(s, jump(live(32'h400, jal, 32'h0, 32'h0, 32'h40), 32'h440));

        // x0 stays zero against regfile, MEM, WB and EX writes to it.
        s = st(32'h500, addi_x0); s.ex_we = 1'b1; s.ex_rd = 5'd0;
        s.mem_we = 1'b1; s.mem_rd = 5'd0; s.mem_data = 32'h55;
        s.wb_we = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'hBEEF;
        cycle(s, live(32'h500, addi_x0, 32'h0, 32'h0, 32'h0));

        // I-type rs1 stall, then MEM wins over WB for x5.
        s = st(32'h600, addi_x5); s.ex_we = 1'b1; s.ex_rd = 5'd5;
        cycle(s, stalled());
        s = st(32'h600, addi_x5); s.mem_we = 1'b1; s.mem_rd = 5'd5; s.mem_data = 32'hA;
        s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'hB;
        cycle(s, live(32'h600, addi_x5, 32'hA, 32'd5, 32'h1));

        // Store: rs2 dependency stalls; negative S immediate.
        s = st(32'h604, sw); s.ex_we = 1'b1; s.ex_rd = 5'd5;
        cycle(s, stalled());
        s = st(32'h604, sw);
        cycle(s, live(32'h604, sw, 32'hFFFF_FFFF, 32'hB, 32'hFFFF_FFFC));

        // Unknown opcode and LUI use no operands, so EX matches never stall.
        s = st(32'h608, unk); s.ex_we = 1'b1; s.ex_rd = 5'd1;
        cycle(s, live(32'h608, unk, 32'd5, 32'd5, 32'h0));
        s = st(32'h60C, lui); s.ex_we = 1'b1; s.ex_rd = 5'd27;
        cycle(s, live(32'h60C, lui, 32'h0, 32'h0, 32'hABCD_E000));

        // Reset in the middle of a stall discards it and clears state.
        s = st(32'h40, add_x3); s.ex_we = 1'b1; s.ex_rd = 5'd3;
        cycle(s, stalled());
        s.rst = 1'b1;
        cycle(s, bubble());
        s.rst = 1'b0;
        cycle(s, stalled());
        s = st(32'h700, addi_x1);
        cycle(s, live(32'h700, addi_x1, 32'h0, 32'h0, 32'h0));

        // Stall counter saturates.
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        exp_scnt = 32'hFFFF_FFFF;
        s = st(32'h40, add_x3); s.ex_we = 1'b1; s.ex_rd = 5'd3;
        cycle(s, stalled());
        release dut.stall_cnt_q;
        cycle(s, stalled());
        cycle(s, stalled());

        if (sb.size() != 0) check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
